// File: rtl/dom_sched_pkg.sv
// Shared types and width helpers for the DOM gadget scheduler and its masked AND gadget.
package dom_sched_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_e;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  // Fresh random bits per op: one W-bit word per unordered share pair.
  function automatic int rw_bits(input int shares, input int w);
    return w * shares * (shares - 1) / 2;
  endfunction

  // Dense index of share pair (i,j), i<j, into the randomness word.
  function automatic int pair_idx(input int i, input int j, input int shares);
    return i * shares - i * (i + 1) / 2 + (j - i - 1);
  endfunction

endpackage

// File: rtl/dom_and_gadget.sv
// Pipelined DOM-indep AND gadget: registered inner/cross-domain terms with pairwise refresh,
// compressed per domain after the register, then LAT-1 further output stages.
module dom_and_gadget
  import dom_sched_pkg::*;
#(
  parameter int SHARES = 2,
  parameter int W      = 8,
  parameter int LAT    = 1,
  localparam int RW    = rw_bits(SHARES, W)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SHARES*W-1:0] a_i,
  input  logic [SHARES*W-1:0] b_i,
  input  logic [RW-1:0]       rnd_i,
  output logic [SHARES*W-1:0] c_o
);

  logic [W-1:0] term_d [SHARES][SHARES];
  logic [W-1:0] term_q [SHARES][SHARES];
  logic [SHARES*W-1:0] comp;

  for (genvar i = 0; i < SHARES; i++) begin : g_row
    for (genvar j = 0; j < SHARES; j++) begin : g_col
      if (i == j) begin : g_inner
        assign term_d[i][j] = a_i[i*W +: W] & b_i[j*W +: W];
      end else if (i < j) begin : g_upper
        assign term_d[i][j] = (a_i[i*W +: W] & b_i[j*W +: W]) ^ rnd_i[pair_idx(i, j, SHARES)*W +: W];
      end else begin : g_lower
        assign term_d[i][j] = (a_i[i*W +: W] & b_i[j*W +: W]) ^ rnd_i[pair_idx(j, i, SHARES)*W +: W];
      end
    end
  end

  // NOTE: datapath registers are reset here only so the result bus reads 0 out of reset;
  // a pure data pipe could skip the reset and save the reset fan-out.
  always_ff @(posedge clk) begin
    if (rst) begin
      term_q <= '{default: '0};
    end else begin
      term_q <= term_d;
    end
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    comp = '0;
    for (int i = 0; i < SHARES; i++) begin
      for (int j = 0; j < SHARES; j++) begin
        comp[i*W +: W] = comp[i*W +: W] ^ term_q[i][j];
      end
    end
  end

  if (LAT > 1) begin : g_out_pipe
    logic [SHARES*W-1:0] pipe_q [LAT-1];
    always_ff @(posedge clk) begin
      if (rst) begin
        pipe_q <= '{default: '0};
      end else begin
        pipe_q[0] <= comp;
        for (int k = 1; k < LAT - 1; k++) pipe_q[k] <= pipe_q[k-1];
      end
    end
    assign c_o = pipe_q[LAT-2];
  end else begin : g_out_direct
    assign c_o = comp;
  end

endmodule

// File: rtl/dom_gadget_scheduler.sv
// Round-robin scheduler sharing one DOM-AND gadget among NREQ masked requesters.
// Optional BURST_LOCK_EN adds req_lock: a locked grantee keeps the round-robin pointer.
module dom_gadget_scheduler
  import dom_sched_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int SHARES = 2,
  parameter int W      = 8,
  parameter int LAT    = 1,
  localparam int RW    = rw_bits(SHARES, W),
  localparam int IDW   = clog2(NREQ),
  localparam int OW    = SHARES * W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*OW-1:0] req_a,
  input  logic [NREQ*OW-1:0] req_b,
  input  logic               rnd_valid,
  output logic               rnd_ready,
  input  logic [RW-1:0]      rnd_data,
  input  logic               halt,
  output logic               idle,
  output logic               rsp_valid,
  output logic [IDW-1:0]     rsp_id,
  output logic [OW-1:0]      rsp_data,
  output logic [15:0]        stall_cnt
`ifdef BURST_LOCK_EN
  ,
  input  logic [NREQ-1:0]    req_lock
`endif
);

  state_e         state_q;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [OW-1:0]  a_q, b_q;
  logic [RW-1:0]  r_q;
  logic [LAT:0]   vld_q;
  logic [IDW-1:0] id_q [LAT+1];
  logic [15:0]    stall_cnt_q;

  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic           issue;
  int             scan_idx;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = int'(rr_ptr_q) + k;
      if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(scan_idx);
      end
    end
  end

  // halt beats a pending issue in the same cycle; reset also blocks grants.
  assign issue = !rst && (state_q == RUN) && grant_found && rnd_valid && !halt;

  always_comb begin
    req_ready = '0;
    if (issue) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    rr_ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
`ifdef BURST_LOCK_EN
    if (req_lock[grant_idx]) rr_ptr_d = grant_idx;
`endif
  end

  assign rnd_ready = issue;
  assign idle      = ~|vld_q & ~issue;
  assign rsp_valid = vld_q[LAT];
  assign rsp_id    = id_q[LAT];
  assign stall_cnt = stall_cnt_q;

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      rr_ptr_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      r_q         <= '0;
      vld_q       <= '0;
      id_q        <= '{default: '0};
      stall_cnt_q <= '0;
    end else begin
      vld_q <= {vld_q[LAT-1:0], issue};
      for (int k = 1; k <= LAT; k++) id_q[k] <= id_q[k-1];

      // Operand regs only load on issue, so the gadget inputs never toggle otherwise.
      if (issue) begin
        a_q      <= req_a[int'(grant_idx)*OW +: OW];
        b_q      <= req_b[int'(grant_idx)*OW +: OW];
        r_q      <= rnd_data;
        id_q[0]  <= grant_idx;
        rr_ptr_q <= rr_ptr_d;
      end

      case (state_q)
        RUN:     if (halt) state_q <= DRAIN;
        DRAIN:   if (!halt && !(|vld_q)) state_q <= RUN;
        default: state_q <= RUN;
      endcase

      if ((state_q == RUN) && !halt && (|req_valid) && !rnd_valid && (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  dom_and_gadget #(
    .SHARES(SHARES),
    .W     (W),
    .LAT   (LAT)
  ) u_gadget (
    .clk  (clk),
    .rst  (rst),
    .a_i  (a_q),
    .b_i  (b_q),
    .rnd_i(r_q),
    .c_o  (rsp_data)
  );

endmodule

// File: tb/tb_dom_gadget_scheduler.sv
// Directed table-driven bench for dom_gadget_scheduler (NREQ=4, SHARES=2, W=8, LAT=1).
module tb_dom_gadget_scheduler;

  localparam int NREQ = 4;
  localparam int SH   = 2;
  localparam int W    = 8;
  localparam int OW   = SH * W;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [NREQ*OW-1:0] req_a, req_b;
  logic              rnd_valid, rnd_ready;
  logic [W-1:0]      rnd_data;
  logic              halt, idle, rsp_valid;
  logic [1:0]        rsp_id;
  logic [OW-1:0]     rsp_data;
  logic [15:0]       stall_cnt;
`ifdef BURST_LOCK_EN
  logic [NREQ-1:0]   req_lock = '0;
`endif

  dom_gadget_scheduler #(.NREQ(NREQ), .SHARES(SH), .W(W), .LAT(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .rnd_valid(rnd_valid),
    .rnd_ready(rnd_ready),
    .rnd_data (rnd_data),
    .halt     (halt),
    .idle     (idle),
    .rsp_valid(rsp_valid),
    .rsp_id   (rsp_id),
    .rsp_data (rsp_data),
    .stall_cnt(stall_cnt)
`ifdef BURST_LOCK_EN
    ,
    .req_lock (req_lock)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  v;
    logic        rv;
    logic [3:0]  ready;
    logic        rsp;
    logic [1:0]  id;
    logic        idl;
    logic [15:0] stall;
  } vec_t;

  vec_t        tbl[$];
  int          total = 0;
  int          bad   = 0;
  logic [W-1:0] ua [NREQ] = '{8'h96, 8'hFF, 8'hA5, 8'h3C};
  logic [W-1:0] ub [NREQ] = '{8'hF0, 8'h81, 8'h7E, 8'h0F};
  logic [W-1:0] ma [NREQ] = '{8'h6D, 8'h13, 8'hC8, 8'h5A};
  logic [W-1:0] mb [NREQ] = '{8'h2B, 8'hE7, 8'h91, 8'h44};
  logic [W-1:0] exp_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] unmask(input logic [OW-1:0] d);
    logic [W-1:0] u;
    u = '0;
    for (int s = 0; s < SH; s++) u = u ^ d[s*W +: W];
    return u;
  endfunction

  task automatic add(input logic [3:0] v, input logic rv, input logic [3:0] ready,
                     input logic rsp, input logic [1:0] id, input logic idl, input logic [15:0] stall);
    vec_t e;
    e.v = v; e.rv = rv; e.ready = ready; e.rsp = rsp; e.id = id; e.idl = idl; e.stall = stall;
    tbl.push_back(e);
  endtask

  // One cycle: drive after the edge, compare at the falling edge, advance past the next edge.
  task automatic cyc(input string tag, input logic [3:0] v, input logic rv, input logic h,
                     input logic [3:0] ready, input logic rsp, input logic [1:0] id,
                     input logic idl, input logic [15:0] stall);
    req_valid = v;
    rnd_valid = rv;
    halt      = h;
    rnd_data  = W'($urandom);
    @(negedge clk);
    if (rsp) exp_data = ua[id] & ub[id];
    check({tag, " req_ready"}, 32'(req_ready), 32'(ready));
    check({tag, " rnd_ready"}, 32'(rnd_ready), 32'(|ready));
    check({tag, " rsp_valid"}, 32'(rsp_valid), 32'(rsp));
    if (rsp) check({tag, " rsp_id"}, 32'(rsp_id), 32'(id));
    check({tag, " idle"}, 32'(idle), 32'(idl));
    check({tag, " stall_cnt"}, 32'(stall_cnt), 32'(stall));
    check({tag, " rsp_data"}, 32'(unmask(rsp_data)), 32'(exp_data));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*OW +: OW] = {ua[i] ^ ma[i], ma[i]};
      req_b[i*OW +: OW] = {ub[i] ^ mb[i], mb[i]};
    end
    exp_data  = '0;
    rst       = 1'b1;
    req_valid = '0;
    rnd_valid = 1'b0;
    halt      = 1'b0;
    rnd_data  = '0;
    @(posedge clk);
    #1;

    // Reset held with requests pending: nothing may be granted.
    cyc("rst", 4'hF, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 1'b1, 16'd0);
    rst = 1'b0;
    check("rst rsp_id", 32'(rsp_id), 32'd0);

    // All four requesters for 8 cycles: strict rotation 0..3, 0..3.
    for (int r = 0; r < 8; r++)
      add(4'hF, 1'b1, 4'(1 << (r % 4)), r >= 2, 2'(r - 2), 1'b0, 16'd0);
    add(4'h0, 1'b1, 4'h0, 1'b1, 2'd2, 1'b0, 16'd0);
    add(4'h0, 1'b1, 4'h0, 1'b1, 2'd3, 1'b0, 16'd0);
    add(4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 1'b1, 16'd0);
    // Single requester 0: rsp two cycles after grant.
    add(4'h1, 1'b1, 4'h1, 1'b0, 2'd0, 1'b0, 16'd0);
    add(4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 16'd0);
    add(4'h0, 1'b1, 4'h0, 1'b1, 2'd0, 1'b0, 16'd0);
    add(4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 1'b1, 16'd0);
    // Pointer at 1 with requesters 0 and 3: scan wraps to 3, then 0.
    add(4'h9, 1'b1, 4'h8, 1'b0, 2'd0, 1'b0, 16'd0);
    add(4'h9, 1'b1, 4'h1, 1'b0, 2'd0, 1'b0, 16'd0);
    add(4'h0, 1'b1, 4'h0, 1'b1, 2'd3, 1'b0, 16'd0);
    add(4'h0, 1'b1, 4'h0, 1'b1, 2'd0, 1'b0, 16'd0);
    add(4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 1'b1, 16'd0);
    // Randomness starved for 10 cycles, then the grant lands the cycle it returns.
    for (int r = 0; r < 10; r++)
      add(4'h3, 1'b0, 4'h0, 1'b0, 2'd0, 1'b1, 16'(r));
    add(4'h3, 1'b1, 4'h2, 1'b0, 2'd0, 1'b0, 16'd10);
    add(4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 16'd10);
    add(4'h0, 1'b1, 4'h0, 1'b1, 2'd1, 1'b0, 16'd10);
    add(4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 1'b1, 16'd10);

    for (int r = 0; r < tbl.size(); r++)
      cyc($sformatf("row%0d", r), tbl[r].v, tbl[r].rv, 1'b0, tbl[r].ready,
          tbl[r].rsp, tbl[r].id, tbl[r].idl, tbl[r].stall);

    // Halt with two ops in flight: both drain, no new grant, resume at pointer 0.
    cyc("h0", 4'hF, 1'b1, 1'b0, 4'h4, 1'b0, 2'd0, 1'b0, 16'd10);
    cyc("h1", 4'hF, 1'b1, 1'b0, 4'h8, 1'b0, 2'd0, 1'b0, 16'd10);
    cyc("h2", 4'hF, 1'b1, 1'b1, 4'h0, 1'b1, 2'd2, 1'b0, 16'd10);
    cyc("h3", 4'hF, 1'b1, 1'b1, 4'h0, 1'b1, 2'd3, 1'b0, 16'd10);
    cyc("h4", 4'hF, 1'b1, 1'b1, 4'h0, 1'b0, 2'd0, 1'b1, 16'd10);
    cyc("h5", 4'hF, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 1'b1, 16'd10);
    cyc("h6", 4'hF, 1'b1, 1'b0, 4'h1, 1'b0, 2'd0, 1'b0, 16'd10);

    // Reset for one cycle with an op in flight: its response is dropped.
    rst = 1'b1;
    cyc("r0", 4'hF, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 16'd10);
    rst = 1'b0;
    exp_data = '0;
    cyc("r1", 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 1'b1, 16'd0);
    check("r1 rsp_id", 32'(rsp_id), 32'd0);
    cyc("r2", 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 1'b1, 16'd0);
    cyc("r3", 4'h4, 1'b1, 1'b0, 4'h4, 1'b0, 2'd0, 1'b0, 16'd0);
    cyc("r4", 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 16'd0);
    cyc("r5", 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 2'd2, 1'b0, 16'd0);
    cyc("r6", 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 1'b1, 16'd0);

`ifdef BURST_LOCK_EN
    // Pointer is at 3; locked requester 0 keeps winning until the lock drops.
    req_lock = 4'h1;
    cyc("l0", 4'h3, 1'b1, 1'b0, 4'h1, 1'b0, 2'd0, 1'b0, 16'd0);
    cyc("l1", 4'h3, 1'b1, 1'b0, 4'h1, 1'b0, 2'd0, 1'b0, 16'd0);
    cyc("l2", 4'h3, 1'b1, 1'b0, 4'h1, 1'b1, 2'd0, 1'b0, 16'd0);
    req_lock = 4'h0;
    cyc("l3", 4'h3, 1'b1, 1'b0, 4'h1, 1'b1, 2'd0, 1'b0, 16'd0);
    cyc("l4", 4'h3, 1'b1, 1'b0, 4'h2, 1'b1, 2'd0, 1'b0, 16'd0);
    cyc("l5", 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 2'd0, 1'b0, 16'd0);
    cyc("l6", 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 2'd1, 1'b0, 16'd0);
    cyc("l7", 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 1'b1, 16'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
